// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operation classes, RV32I major opcodes and the
// immediate-format selector used by the decode stage.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ALU     = 4'd0,
        OP_ALUI    = 4'd1,
        OP_LOAD    = 4'd2,
        OP_STORE   = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_JAL     = 4'd5,
        OP_JALR    = 4'd6,
        OP_LUI     = 4'd7,
        OP_AUIPC   = 4'd8,
        OP_ILLEGAL = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/id_stage_if.sv
// Fetch, register-bank read, execute and writeback signals around the decode
// stage. The slave modport is the decode stage's view; master is its environment.
interface id_stage_if #(
    parameter int NUMREGS   = 32,
    parameter int DATAWIDTH = 32
);
    import cpu_pkg::*;

    localparam int AW = $clog2(NUMREGS);

    logic                 if_valid_i;
    logic [31:0]          if_instr_i;
    logic [DATAWIDTH-1:0] if_pc_i;
    logic                 id_ready_o;

    logic                 re_a_o;
    logic                 re_b_o;
    logic [AW-1:0]        raddr_a_o;
    logic [AW-1:0]        raddr_b_o;

    logic                 ex_valid_o;
    logic                 ex_ready_i;
    op_e                  ex_op_o;
    logic [9:0]           ex_funct_o;
    logic [AW-1:0]        ex_rd_o;
    logic                 ex_we_o;
    logic [DATAWIDTH-1:0] ex_imm_o;
    logic [DATAWIDTH-1:0] ex_pc_o;

    logic                 wb_we_i;
    logic [AW-1:0]        wb_waddr_i;
    logic                 flush_i;

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, ex_ready_i, wb_we_i, wb_waddr_i, flush_i,
        output id_ready_o, re_a_o, re_b_o, raddr_a_o, raddr_b_o,
        output ex_valid_o, ex_op_o, ex_funct_o, ex_rd_o, ex_we_o, ex_imm_o, ex_pc_o
    );

    modport master (
        output if_valid_i, if_instr_i, if_pc_i, ex_ready_i, wb_we_i, wb_waddr_i, flush_i,
        input  id_ready_o, re_a_o, re_b_o, raddr_a_o, raddr_b_o,
        input  ex_valid_o, ex_op_o, ex_funct_o, ex_rd_o, ex_we_o, ex_imm_o, ex_pc_o
    );

endinterface

// File: rtl/id_scoreboard.sv
// One pending bit per architectural register. A set wins over any clear of the
// same register in the same cycle; register 0 can never become pending.
module id_scoreboard #(
    parameter int NUMREGS = 32,
    parameter int AW      = $clog2(NUMREGS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               set_en_i,
    input  logic [AW-1:0]      set_addr_i,
    input  logic               wb_clr_en_i,
    input  logic [AW-1:0]      wb_clr_addr_i,
    input  logic               fl_clr_en_i,
    input  logic [AW-1:0]      fl_clr_addr_i,
    output logic [NUMREGS-1:0] pending_o
);

    localparam logic [NUMREGS-1:0] NONZERO_MASK = {{(NUMREGS-1){1'b1}}, 1'b0};

    logic [NUMREGS-1:0] pending_q;
    logic [NUMREGS-1:0] pending_d;
    logic [NUMREGS-1:0] set_vec_s;
    logic [NUMREGS-1:0] wb_vec_s;
    logic [NUMREGS-1:0] fl_vec_s;

    // Expand the set and clear requests into one-hot register masks.
    always_comb begin
        set_vec_s = {NUMREGS{1'b0}};
        wb_vec_s  = {NUMREGS{1'b0}};
        fl_vec_s  = {NUMREGS{1'b0}};
        for (int r = 0; r < NUMREGS; r++) begin
            set_vec_s[r] = set_en_i    && (set_addr_i    == AW'(r));
            wb_vec_s[r]  = wb_clr_en_i && (wb_clr_addr_i == AW'(r));
            fl_vec_s[r]  = fl_clr_en_i && (fl_clr_addr_i == AW'(r));
        end
    end

    // Next pending vector: clears first, then sets on top so a set wins.
    always_comb begin
        pending_d = (set_vec_s | (pending_q & ~wb_vec_s & ~fl_vec_s)) & NONZERO_MASK;
    end

    // Pending-bit state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= {NUMREGS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: field and immediate decode, register-read steering,
// operand interlock against the scoreboard and the registered hand-off to execute.
module id_stage
    import cpu_pkg::*;
#(
    parameter int NUMREGS   = 32,
    parameter int DATAWIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    id_stage_if.slave bus
);

    localparam int AW = $clog2(NUMREGS);

    logic [31:0]          instr_s;
    logic [6:0]           opcode_s;
    logic [AW-1:0]        rd_s;
    logic [AW-1:0]        rs1_s;
    logic [AW-1:0]        rs2_s;
    op_e                  dec_op_s;
    imm_fmt_e             dec_fmt_s;
    logic                 dec_use_a_s;
    logic                 dec_use_b_s;
    logic                 dec_wr_s;
    logic                 dec_we_s;
    logic [31:0]          imm32_s;
    logic [DATAWIDTH-1:0] dec_imm_s;

    logic [NUMREGS-1:0]   pending_s;
    logic                 haz_a_s;
    logic                 haz_b_s;
    logic                 hazard_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 hold_s;
    logic                 sb_set_s;
    logic                 sb_fl_clr_s;

    logic                 re_a_s;
    logic                 re_b_s;
    logic [AW-1:0]        raddr_a_s;
    logic [AW-1:0]        raddr_b_s;

    logic                 ex_valid_q, ex_valid_d;
    op_e                  ex_op_q, ex_op_d;
    logic [9:0]           ex_funct_q, ex_funct_d;
    logic [AW-1:0]        ex_rd_q, ex_rd_d;
    logic                 ex_we_q, ex_we_d;
    logic [DATAWIDTH-1:0] ex_imm_q, ex_imm_d;
    logic [DATAWIDTH-1:0] ex_pc_q, ex_pc_d;
    logic [AW-1:0]        hold_rs1_q, hold_rs1_d;
    logic [AW-1:0]        hold_rs2_q, hold_rs2_d;
    logic                 hold_use_a_q, hold_use_a_d;
    logic                 hold_use_b_q, hold_use_b_d;

    assign instr_s  = bus.if_instr_i;
    assign opcode_s = instr_s[6:0];
    assign rd_s     = AW'(instr_s[11:7]);
    assign rs1_s    = AW'(instr_s[19:15]);
    assign rs2_s    = AW'(instr_s[24:20]);

    // Opcode to operation class, immediate format and register usage.
    always_comb begin
        dec_op_s    = OP_ILLEGAL;
        dec_fmt_s   = IMM_NONE;
        dec_use_a_s = 1'b0;
        dec_use_b_s = 1'b0;
        dec_wr_s    = 1'b0;
        case (opcode_s)
            OPC_OP:     begin dec_op_s = OP_ALU;    dec_use_a_s = 1'b1; dec_use_b_s = 1'b1; dec_wr_s = 1'b1; end
            OPC_OPIMM:  begin dec_op_s = OP_ALUI;   dec_fmt_s = IMM_I; dec_use_a_s = 1'b1; dec_wr_s = 1'b1; end
            OPC_LOAD:   begin dec_op_s = OP_LOAD;   dec_fmt_s = IMM_I; dec_use_a_s = 1'b1; dec_wr_s = 1'b1; end
            OPC_STORE:  begin dec_op_s = OP_STORE;  dec_fmt_s = IMM_S; dec_use_a_s = 1'b1; dec_use_b_s = 1'b1; end
            OPC_BRANCH: begin dec_op_s = OP_BRANCH; dec_fmt_s = IMM_B; dec_use_a_s = 1'b1; dec_use_b_s = 1'b1; end
            OPC_JAL:    begin dec_op_s = OP_JAL;    dec_fmt_s = IMM_J; dec_wr_s = 1'b1; end
            OPC_JALR:   begin dec_op_s = OP_JALR;   dec_fmt_s = IMM_I; dec_use_a_s = 1'b1; dec_wr_s = 1'b1; end
            OPC_LUI:    begin dec_op_s = OP_LUI;    dec_fmt_s = IMM_U; dec_wr_s = 1'b1; end
            OPC_AUIPC:  begin dec_op_s = OP_AUIPC;  dec_fmt_s = IMM_U; dec_wr_s = 1'b1; end
            default:    begin dec_op_s = OP_ILLEGAL; end
        endcase
    end

    assign dec_we_s = dec_wr_s && (rd_s != {AW{1'b0}});

    // Immediate assembly; every format is built as 32 bits and sign-extended below.
    always_comb begin
        imm32_s = 32'd0;
        case (dec_fmt_s)
            IMM_I:   imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
            IMM_S:   imm32_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
            IMM_B:   imm32_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
            IMM_U:   imm32_s = {instr_s[31:12], 12'd0};
            IMM_J:   imm32_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign dec_imm_s = DATAWIDTH'($signed(imm32_s));

    // A writeback in this cycle is forwarded by the bank, so it resolves the hazard at once.
    assign haz_a_s  = dec_use_a_s && pending_s[rs1_s] && !(bus.wb_we_i && (bus.wb_waddr_i == rs1_s));
    assign haz_b_s  = dec_use_b_s && pending_s[rs2_s] && !(bus.wb_we_i && (bus.wb_waddr_i == rs2_s));
    assign hazard_s = haz_a_s || haz_b_s;

    assign hold_s      = ex_valid_q && !bus.ex_ready_i;
    assign ready_s     = (!ex_valid_q || bus.ex_ready_i) && !hazard_s && !bus.flush_i;
    assign accept_s    = bus.if_valid_i && ready_s;
    assign sb_set_s    = accept_s && dec_we_s;
    assign sb_fl_clr_s = bus.flush_i && ex_valid_q && ex_we_q;

    id_scoreboard #(
        .NUMREGS (NUMREGS),
        .AW      (AW)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .set_en_i      (sb_set_s),
        .set_addr_i    (rd_s),
        .wb_clr_en_i   (bus.wb_we_i),
        .wb_clr_addr_i (bus.wb_waddr_i),
        .fl_clr_en_i   (sb_fl_clr_s),
        .fl_clr_addr_i (ex_rd_q),
        .pending_o     (pending_s)
    );

    // Bank read steering: re-present the held sources so registered read data stays valid.
    always_comb begin
        re_a_s    = 1'b0;
        re_b_s    = 1'b0;
        raddr_a_s = {AW{1'b0}};
        raddr_b_s = {AW{1'b0}};
        if (hold_s) begin
            re_a_s    = hold_use_a_q;
            re_b_s    = hold_use_b_q;
            raddr_a_s = hold_rs1_q;
            raddr_b_s = hold_rs2_q;
        end else if (accept_s) begin
            re_a_s    = dec_use_a_s;
            re_b_s    = dec_use_b_s;
            raddr_a_s = rs1_s;
            raddr_b_s = rs2_s;
        end else begin
            re_a_s    = 1'b0;
            re_b_s    = 1'b0;
        end
    end

    // Next state of the execute-side register: flush, load on accept, drain on consume.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op_d      = ex_op_q;
        ex_funct_d   = ex_funct_q;
        ex_rd_d      = ex_rd_q;
        ex_we_d      = ex_we_q;
        ex_imm_d     = ex_imm_q;
        ex_pc_d      = ex_pc_q;
        hold_rs1_d   = hold_rs1_q;
        hold_rs2_d   = hold_rs2_q;
        hold_use_a_d = hold_use_a_q;
        hold_use_b_d = hold_use_b_q;
        if (bus.flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept_s) begin
            ex_valid_d   = 1'b1;
            ex_op_d      = dec_op_s;
            ex_funct_d   = {instr_s[31:25], instr_s[14:12]};
            ex_rd_d      = rd_s;
            ex_we_d      = dec_we_s;
            ex_imm_d     = dec_imm_s;
            ex_pc_d      = bus.if_pc_i;
            hold_rs1_d   = rs1_s;
            hold_rs2_d   = rs2_s;
            hold_use_a_d = dec_use_a_s;
            hold_use_b_d = dec_use_b_s;
        end else if (bus.ex_ready_i) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Execute-side pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q   <= 1'b0;
            ex_op_q      <= OP_ILLEGAL;
            ex_funct_q   <= 10'd0;
            ex_rd_q      <= {AW{1'b0}};
            ex_we_q      <= 1'b0;
            ex_imm_q     <= {DATAWIDTH{1'b0}};
            ex_pc_q      <= {DATAWIDTH{1'b0}};
            hold_rs1_q   <= {AW{1'b0}};
            hold_rs2_q   <= {AW{1'b0}};
            hold_use_a_q <= 1'b0;
            hold_use_b_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op_q      <= ex_op_d;
            ex_funct_q   <= ex_funct_d;
            ex_rd_q      <= ex_rd_d;
            ex_we_q      <= ex_we_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_q      <= ex_pc_d;
            hold_rs1_q   <= hold_rs1_d;
            hold_rs2_q   <= hold_rs2_d;
            hold_use_a_q <= hold_use_a_d;
            hold_use_b_q <= hold_use_b_d;
        end
    end

    assign bus.id_ready_o = ready_s;
    assign bus.re_a_o     = re_a_s;
    assign bus.re_b_o     = re_b_s;
    assign bus.raddr_a_o  = raddr_a_s;
    assign bus.raddr_b_o  = raddr_b_s;
    assign bus.ex_valid_o = ex_valid_q;
    assign bus.ex_op_o    = ex_op_q;
    assign bus.ex_funct_o = ex_funct_q;
    assign bus.ex_rd_o    = ex_rd_q;
    assign bus.ex_we_o    = ex_we_q;
    assign bus.ex_imm_o   = ex_imm_q;
    assign bus.ex_pc_o    = ex_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared cycle by cycle against an instruction-level reference model.
module tb_id_stage;
    import cpu_pkg::*;

    localparam int NR = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    id_stage_if #(.NUMREGS(NR), .DATAWIDTH(DW)) bus ();

    id_stage #(.NUMREGS(NR), .DATAWIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the instruction held toward execute and the busy registers.
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit   [31:0] m_pend;
    logic [31:0] pc_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit uses1(input logic [31:0] ins);
        return ins[6:0] inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
    endfunction

    function automatic bit uses2(input logic [31:0] ins);
        return ins[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic bit writes(input logic [31:0] ins);
        return (ins[6:0] inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC})
               && (ins[11:7] != 5'd0);
    endfunction

    function automatic op_e ref_op(input logic [31:0] ins);
        case (ins[6:0])
            OPC_OP:     return OP_ALU;
            OPC_OPIMM:  return OP_ALUI;
            OPC_LOAD:   return OP_LOAD;
            OPC_STORE:  return OP_STORE;
            OPC_BRANCH: return OP_BRANCH;
            OPC_JAL:    return OP_JAL;
            OPC_JALR:   return OP_JALR;
            OPC_LUI:    return OP_LUI;
            OPC_AUIPC:  return OP_AUIPC;
            default:    return OP_ILLEGAL;
        endcase
    endfunction

    // Immediate value computed arithmetically from the instruction fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int sx, sgn, f1, f2, f3;
        sx  = $signed(ins);
        sgn = sx >>> 31;
        case (ins[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR: return 32'(sx >>> 20);
            OPC_STORE: begin
                f1 = ins[11:7];
                return 32'((sx >>> 25) * 32 + f1);
            end
            OPC_BRANCH: begin
                f1 = ins[7]; f2 = ins[30:25]; f3 = ins[11:8];
                return 32'(sgn * 4096 + f1 * 2048 + f2 * 32 + f3 * 2);
            end
            OPC_JAL: begin
                f1 = ins[19:12]; f2 = ins[20]; f3 = ins[30:21];
                return 32'(sgn * 1048576 + f1 * 4096 + f2 * 2048 + f3 * 2);
            end
            OPC_LUI, OPC_AUIPC: return ins & 32'hFFFFF000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r] && !(bus.wb_we_i && (bus.wb_waddr_i == r));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 9))
            0:       w[6:0] = OPC_OP;
            1:       w[6:0] = OPC_OPIMM;
            2:       w[6:0] = OPC_LOAD;
            3:       w[6:0] = OPC_STORE;
            4:       w[6:0] = OPC_BRANCH;
            5:       w[6:0] = OPC_JAL;
            6:       w[6:0] = OPC_JALR;
            7:       w[6:0] = OPC_LUI;
            8:       w[6:0] = OPC_AUIPC;
            default: w[6:0] = 7'b0001011;
        endcase
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input bit exr,
                         input bit wbe, input logic [4:0] wba, input bit fl);
        bus.if_valid_i = v;
        bus.if_instr_i = ins;
        bus.if_pc_i    = pc_cnt;
        bus.ex_ready_i = exr;
        bus.wb_we_i    = wbe;
        bus.wb_waddr_i = wba;
        bus.flush_i    = fl;
        pc_cnt         = pc_cnt + 32'd4;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_pc    = 32'd0;
        m_pend  = 32'd0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ex_valid"}, bus.ex_valid_o, 1'b0);
        chk({tag, "_ex_we"},    bus.ex_we_o,    1'b0);
        chk({tag, "_ex_op"},    bus.ex_op_o,    OP_ILLEGAL);
        chk({tag, "_ex_rd"},    bus.ex_rd_o,    5'd0);
        chk({tag, "_ex_imm"},   bus.ex_imm_o,   32'd0);
        chk({tag, "_ex_pc"},    bus.ex_pc_o,    32'd0);
        chk({tag, "_ex_funct"}, bus.ex_funct_o, 10'd0);
    endtask

    // One clock: check all outputs against the model at the falling edge, then advance it.
    task automatic tick();
        logic [31:0] ins;
        bit          hold, haz, rdy, acc, ea, eb;
        logic [4:0]  aa, ab;
        @(negedge clk);
        ins  = bus.if_instr_i;
        hold = m_valid && !bus.ex_ready_i;
        haz  = (uses1(ins) && busy(ins[19:15])) || (uses2(ins) && busy(ins[24:20]));
        rdy  = (!m_valid || bus.ex_ready_i) && !haz && !bus.flush_i;
        acc  = bus.if_valid_i && rdy;
        if (hold) begin
            ea = uses1(m_instr); eb = uses2(m_instr); aa = m_instr[19:15]; ab = m_instr[24:20];
        end else if (acc) begin
            ea = uses1(ins); eb = uses2(ins); aa = ins[19:15]; ab = ins[24:20];
        end else begin
            ea = 1'b0; eb = 1'b0; aa = 5'd0; ab = 5'd0;
        end
        chk("id_ready", bus.id_ready_o, rdy);
        chk("re_a", bus.re_a_o, ea);
        chk("re_b", bus.re_b_o, eb);
        if (ea) chk("raddr_a", bus.raddr_a_o, aa);
        if (eb) chk("raddr_b", bus.raddr_b_o, ab);
        chk("ex_valid", bus.ex_valid_o, m_valid);
        if (m_valid) begin
            chk("ex_op",    bus.ex_op_o,    ref_op(m_instr));
            chk("ex_rd",    bus.ex_rd_o,    m_instr[11:7]);
            chk("ex_we",    bus.ex_we_o,    writes(m_instr));
            chk("ex_imm",   bus.ex_imm_o,   ref_imm(m_instr));
            chk("ex_pc",    bus.ex_pc_o,    m_pc);
            chk("ex_funct", bus.ex_funct_o, {m_instr[31:25], m_instr[14:12]});
        end
        @(posedge clk);
        #1;
        if (bus.wb_we_i) m_pend[bus.wb_waddr_i] = 1'b0;
        if (bus.flush_i && m_valid && writes(m_instr)) m_pend[m_instr[11:7]] = 1'b0;
        if (acc && writes(ins)) m_pend[ins[11:7]] = 1'b1;
        m_pend[0] = 1'b0;
        if (bus.flush_i) m_valid = 1'b0;
        else if (acc) begin m_valid = 1'b1; m_instr = ins; m_pc = bus.if_pc_i; end
        else if (bus.ex_ready_i) m_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        pc_cnt   = 32'h100;
        rst      = 1'b1;
        drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        model_reset();
        #12;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", bus.id_ready_o, 1'b1);

        // addi x5,x0,7
        drive(1'b1, 32'h00700293, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("addi_re_a", bus.re_a_o, 1'b1);
        chk("addi_raddr_a", bus.raddr_a_o, 5'd0);
        chk("addi_re_b", bus.re_b_o, 1'b0);
        tick();
        chk("addi_op", bus.ex_op_o, OP_ALUI);
        chk("addi_rd", bus.ex_rd_o, 5'd5);
        chk("addi_imm", bus.ex_imm_o, 32'd7);
        chk("addi_we", bus.ex_we_o, 1'b1);

        // add x6,x5,x5 stalls on x5 until its writeback arrives
        drive(1'b1, 32'h00528333, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("raw_stall", bus.id_ready_o, 1'b0);
        tick();
        drive(1'b1, 32'h00528333, 1'b1, 1'b1, 5'd5, 1'b0);
        #1;
        chk("raw_fwd_ready", bus.id_ready_o, 1'b1);
        tick();
        chk("add_rd", bus.ex_rd_o, 5'd6);
        chk("add_op", bus.ex_op_o, OP_ALU);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd6, 1'b0);
        tick();

        // beq x1,x2,-4 and lui x1,0x12345
        drive(1'b1, 32'hFE208EE3, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        chk("beq_imm", bus.ex_imm_o, 32'hFFFFFFFC);
        chk("beq_we", bus.ex_we_o, 1'b0);
        drive(1'b1, 32'h123450B7, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        chk("lui_imm", bus.ex_imm_o, 32'h12345000);
        chk("lui_we", bus.ex_we_o, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 1'b0);
        tick();

        // addi x7,x3,3 held three cycles, then addi x8,x0,4 accepted on release
        drive(1'b1, 32'h00318393, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00400413, 1'b0, 1'b0, 5'd0, 1'b0);
            #1;
            chk("stall_ready", bus.id_ready_o, 1'b0);
            chk("stall_re_a", bus.re_a_o, 1'b1);
            chk("stall_raddr_a", bus.raddr_a_o, 5'd3);
            chk("stall_imm", bus.ex_imm_o, 32'd3);
            chk("stall_rd", bus.ex_rd_o, 5'd7);
            tick();
        end
        drive(1'b1, 32'h00400413, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("release_ready", bus.id_ready_o, 1'b1);
        tick();
        chk("release_rd", bus.ex_rd_o, 5'd8);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd7, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();

        // flush a held addi x5, then x5 must not be busy
        drive(1'b1, 32'h00700293, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 32'h00400413, 1'b0, 1'b0, 5'd0, 1'b1);
        #1;
        chk("flush_ready", bus.id_ready_o, 1'b0);
        tick();
        chk("flush_valid", bus.ex_valid_o, 1'b0);
        drive(1'b1, 32'h00528333, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("flush_x5_free", bus.id_ready_o, 1'b1);
        tick();
        drive(1'b1, 32'h00100013, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();

        // reset in the middle of a stall
        bus.if_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset("mid");
        chk("mid_ready", bus.id_ready_o, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h006303B3, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("reset_x6_free", bus.id_ready_o, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd7, 1'b0);
        tick();

        // addi x0,x0,1 then add x1,x0,x0
        drive(1'b1, 32'h00100013, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        chk("x0_we", bus.ex_we_o, 1'b0);
        drive(1'b1, 32'h000000B3, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("x0_no_stall", bus.id_ready_o, 1'b1);
        tick();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 8), rand_instr(), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NUMREGS, default 32, number of architectural registers (register address width $clog2(NUMREGS)).
REQ-002 SHALL have parameter DATAWIDTH, default 32, instruction/PC/immediate width.
REQ-003 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 if_valid_i  in  1  fetch holds a valid instruction.
REQ-006 if_instr_i  in  32  RV32I instruction word.
REQ-007 if_pc_i  in  DATAWIDTH  PC of if_instr_i.
REQ-008 id_ready_o  out  1  stage accepts the fetch instruction this cycle.
REQ-009 re_a_o, re_b_o  out  1 each  register-bank read enables (rs1, rs2).
REQ-010 raddr_a_o, raddr_b_o  out  5 each  register-bank read addresses.
REQ-011 ex_valid_o  out  1  decoded instruction valid toward execute.
REQ-012 ex_ready_i  in  1  execute consumes the instruction this cycle.
REQ-013 ex_op_o  out  op_e  operation class; ex_funct_o  out  10  {funct7,funct3}.
REQ-014 ex_rd_o  out  5; ex_we_o  out  1; ex_imm_o  out  DATAWIDTH; ex_pc_o  out  DATAWIDTH.
REQ-015 wb_we_i  in  1; wb_waddr_i  in  5  writeback port, same signals as driven to the bank write port.
REQ-016 flush_i  in  1  discard the instruction held toward execute.

Function
REQ-017 accept = if_valid_i & id_ready_o; id_ready_o = (~ex_valid_o | ex_ready_i) & ~hazard & ~flush_i.
REQ-018 Decoded fields SHALL register into ex_* on accept; ex_* outputs SHALL appear one cycle after accept, aligned with the bank's registered read data.
REQ-019 Read enables/addresses SHALL be combinational: on accept, rs1/rs2 of if_instr_i with re_* = 1 only for formats using that source; while ex_valid_o & ~ex_ready_i, the held instruction's rs1/rs2 SHALL be re-presented so bank read data stays valid.
REQ-020 With no accept and no hold, re_a_o = re_b_o = 0.
REQ-021 Op classes: ALU, ALUI, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL; unknown opcode -> ILLEGAL, ex_we_o = 0.
REQ-022 Immediates SHALL be sign-extended to DATAWIDTH per I/S/B/U/J format; B/J bit 0 = 0; U low 12 bits = 0; R-type imm = 0.
REQ-023 ex_we_o = 1 only for ALU, ALUI, LOAD, JAL, JALR, LUI, AUIPC with rd != 0.
REQ-024 Scoreboard: one pending bit per register; set on accept when decoded we=1; cleared when wb_we_i & wb_waddr_i matches.
REQ-025 Same-cycle set and clear of one register: set SHALL win.
REQ-026 hazard = used source with pending bit set and not cleared this cycle (bank forwards same-cycle writes); register 0 never pending.
REQ-027 flush_i SHALL clear ex_valid_o next cycle and clear the pending bit of the flushed instruction's rd if its we=1; no accept in a flush cycle.
REQ-028 ex_valid_o clears on ex_ready_i without a new accept; ex_* hold stable while ex_valid_o & ~ex_ready_i.

Reset
REQ-029 During rst_i: ex_valid_o = 0, ex_we_o = 0, ex_op_o = ILLEGAL, ex_rd/imm/pc/funct = 0, all pending bits = 0; id_ready_o = 1 after release.
REQ-030 Reset mid-operation SHALL discard the held instruction without retaining scoreboard state.

Structure
REQ-031 op_e enum and RV32I opcode constants SHALL live in shared package cpu_pkg.
REQ-032 Scoreboard SHALL be sub-module id_scoreboard (set/clear ports, pending vector out); decode/immediate logic stays in id_stage.

Verification
REQ-033 addi x5,x0,7 (0x00700293) accepted -> next cycle ex_op=ALUI, ex_rd=5, ex_imm=7, ex_we=1, re_a=1/raddr_a=0, re_b=0.
REQ-034 addi x5 then add x6,x5,x5 back-to-back, no writeback -> id_ready_o=0 for add; wb_we_i=1, waddr=5 -> add accepted that cycle.
REQ-035 beq with imm -4 -> ex_imm=0xFFFFFFFC, ex_we=0; lui x1,0x12345 -> ex_imm=0x12345000.
REQ-036 ex_ready_i=0 for 3 cycles after accept -> ex_* and raddr_* stable, id_ready_o=0; ex_ready_i=1 -> next accept same cycle.
REQ-037 flush_i with held addi x5 -> ex_valid_o=0 next cycle, x5 not pending; rst_i mid-stall -> all outputs at reset values immediately.
REQ-038 addi x0,x0,1 then add x1,x0,x0 -> no hazard stall, ex_we=0 for first.
